// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall/flush controller for the front-end pipeline. It merges the
//   jump stall (detected in ID, resolved at WB commit) with any number of
//   structural "full" sources, and drives per-stage hold/bubble vectors plus
//   the PC replay/redirect controls. After a jump resolves, the stale IFID
//   slot is bubbled for DRAIN_NOPS cycles.
//
//   All outputs are registered and lag their inputs by one cycle.
//
// Parameters
//   ADDR_WIDTH      PC / jump target width
//   NUM_STAGES      controlled stages (0=PIF, 1=IFID, 2=ID, 3=IDEX, ...)
//   NUM_FULL_SRC    number of structural-full request inputs
//   FULL_HOLD_DEPTH stages [0..FULL_HOLD_DEPTH-1] hold on full,
//                   stage FULL_HOLD_DEPTH is bubbled
//   DRAIN_NOPS      IFID bubbles after jump resolution (1..15)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_jump_detect    ID holds a possible-jump instruction
//   full_req          structural-full requests (level)
//   wb_commit_jump    WB commits a jump-class instruction
//   wb_jump_taken     qualifies wb_commit_jump: redirect required
//   wb_jump_addr      redirect target
//   stage_hold        1 = stage register keeps its contents
//   stage_bubble      1 = stage register loads a NOP
//   pc_replay         PIF reloads next-PC with current PC
//   pc_redirect_en    PIF loads pc_redirect_addr
//   pc_redirect_addr  registered jump target
//   jump_pending      high while waiting for the jump to resolve
//
// Optional feature (macro STALL_PERF_CNT_EN)
//   perf_jump_cyc / perf_full_cyc / perf_drain_cyc: saturating 32-bit cycle
//   counters for waiting-on-jump, structural-full and drain cycles.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned NUM_FULL_SRC    = 2,
  parameter int unsigned FULL_HOLD_DEPTH = 3,
  parameter int unsigned DRAIN_NOPS      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_jump_detect,
  input  logic [NUM_FULL_SRC-1:0] full_req,
  input  logic                    wb_commit_jump,
  input  logic                    wb_jump_taken,
  input  logic [ADDR_WIDTH-1:0]   wb_jump_addr,
  output logic [NUM_STAGES-1:0]   stage_hold,
  output logic [NUM_STAGES-1:0]   stage_bubble,
  output logic                    pc_replay,
  output logic                    pc_redirect_en,
  output logic [ADDR_WIDTH-1:0]   pc_redirect_addr,
  output logic                    jump_pending
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]             perf_jump_cyc,
  output logic [31:0]             perf_full_cyc,
  output logic [31:0]             perf_drain_cyc
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_JWAIT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_NOPS);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    full_any;
  logic                    full_q;
  logic [NUM_STAGES-1:0]   hold_q, hold_d;
  logic [NUM_STAGES-1:0]   bubble_q, bubble_d;
  logic                    replay_q, replay_d;
  logic                    redir_en_q, redir_en_d;
  logic [ADDR_WIDTH-1:0]   redir_addr_q, redir_addr_d;
  logic                    pending_q, pending_d;

  assign full_any = |full_req;

  // Next state, drain counter and registered-output inputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    replay_d     = 1'b0;
    redir_en_d   = 1'b0;
    redir_addr_d = redir_addr_q;

    unique case (state_q)
      S_RUN: begin
        if (id_jump_detect && !full_any) begin
          state_d  = S_JWAIT;
          replay_d = 1'b1;
        end
      end
      S_JWAIT: begin
        if (wb_commit_jump) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
          if (wb_jump_taken) begin
            redir_en_d   = 1'b1;
            redir_addr_d = wb_jump_addr;
          end
        end
      end
      S_DRAIN: begin
        // full_q is the full stall currently visible at the outputs: a DRAIN
        // cycle only counts when its IFID bubble was not masked by a hold,
        // so every drain NOP actually reaches the pipeline.
        if (!full_q) begin
          if (cnt_q <= 4'd1) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    pending_d = (state_d == S_JWAIT);

    hold_d   = '0;
    bubble_d = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i < FULL_HOLD_DEPTH)  hold_d[i]   = full_any;
      if (i == FULL_HOLD_DEPTH) bubble_d[i] = full_any;
    end
    bubble_d[1] = bubble_d[1] | (state_d != S_RUN);
    // A held stage never also loads a NOP
    bubble_d = bubble_d & ~hold_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      hold_q       <= '0;
      bubble_q     <= '0;
      replay_q     <= 1'b0;
      redir_en_q   <= 1'b0;
      redir_addr_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_q       <= full_any;
      hold_q       <= hold_d;
      bubble_q     <= bubble_d;
      replay_q     <= replay_d;
      redir_en_q   <= redir_en_d;
      redir_addr_q <= redir_addr_d;
      pending_q    <= pending_d;
    end
  end

  assign stage_hold       = hold_q;
  assign stage_bubble     = bubble_q;
  assign pc_replay        = replay_q;
  assign pc_redirect_en   = redir_en_q;
  assign pc_redirect_addr = redir_addr_q;
  assign jump_pending     = pending_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_jump_q, perf_full_q, perf_drain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jump_q  <= '0;
      perf_full_q  <= '0;
      perf_drain_q <= '0;
    end else begin
      if ((state_q == S_JWAIT) && (perf_jump_q != '1))
        perf_jump_q <= perf_jump_q + 32'd1;
      if (full_any && (perf_full_q != '1))
        perf_full_q <= perf_full_q + 32'd1;
      if ((state_q == S_DRAIN) && (perf_drain_q != '1))
        perf_drain_q <= perf_drain_q + 32'd1;
    end
  end

  assign perf_jump_cyc  = perf_jump_q;
  assign perf_full_cyc  = perf_full_q;
  assign perf_drain_cyc = perf_drain_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl. Three instances differing
// only in DRAIN_NOPS (1, 2, 3) share the stimulus; each scenario selects the
// instance whose outputs are checked. Each stimulus row carries the outputs
// expected during the cycle in which that row's inputs are applied.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_jump_detect = 1'b0;
  logic [1:0]  full_req = '0;
  logic        wb_commit_jump = 1'b0;
  logic        wb_jump_taken = 1'b0;
  logic [31:0] wb_jump_addr = '0;

  logic [3:0]  hold_v  [1:3];
  logic [3:0]  bub_v   [1:3];
  logic        rp_v    [1:3];
  logic        rd_v    [1:3];
  logic        jp_v    [1:3];
  logic [31:0] ra_v    [1:3];
`ifdef STALL_PERF_CNT_EN
  logic [31:0] pj_v    [1:3];
  logic [31:0] pf_v    [1:3];
  logic [31:0] pd_v    [1:3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    pipe_stall_ctrl #(
      .ADDR_WIDTH      (32),
      .NUM_STAGES      (4),
      .NUM_FULL_SRC    (2),
      .FULL_HOLD_DEPTH (3),
      .DRAIN_NOPS      (g)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_jump_detect   (id_jump_detect),
      .full_req         (full_req),
      .wb_commit_jump   (wb_commit_jump),
      .wb_jump_taken    (wb_jump_taken),
      .wb_jump_addr     (wb_jump_addr),
      .stage_hold       (hold_v[g]),
      .stage_bubble     (bub_v[g]),
      .pc_replay        (rp_v[g]),
      .pc_redirect_en   (rd_v[g]),
      .pc_redirect_addr (ra_v[g]),
      .jump_pending     (jp_v[g])
`ifdef STALL_PERF_CNT_EN
      ,
      .perf_jump_cyc    (pj_v[g]),
      .perf_full_cyc    (pf_v[g]),
      .perf_drain_cyc   (pd_v[g])
`endif
    );
  end

  typedef struct {
    int          sel;
    int          row;
    string       name;
    logic        rp;
    logic        rd;
    logic        jp;
    logic [3:0]  h;
    logic [3:0]  b;
    logic [31:0] ra;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          sel      = 1;
  int          row      = 0;
  string       scen     = "init";
  logic [31:0] exp_ra   = '0;

  localparam logic [3:0] H  = 4'b0111;
  localparam logic [3:0] FB = 4'b1000;
  localparam logic [3:0] B1 = 4'b0010;

  // Monitor: one expected entry per cycle, compared away from the clock edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (rp_v[e.sel] !== e.rp || rd_v[e.sel] !== e.rd || jp_v[e.sel] !== e.jp ||
          hold_v[e.sel] !== e.h || bub_v[e.sel] !== e.b || ra_v[e.sel] !== e.ra) begin
        $display("FAIL %s row %0d dut%0d: got rp=%b rd=%b jp=%b hold=%b bub=%b addr=%h; exp rp=%b rd=%b jp=%b hold=%b bub=%b addr=%h",
                 e.name, e.row, e.sel, rp_v[e.sel], rd_v[e.sel], jp_v[e.sel],
                 hold_v[e.sel], bub_v[e.sel], ra_v[e.sel],
                 e.rp, e.rd, e.jp, e.h, e.b, e.ra);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic step(input logic rn, input logic jd, input logic [1:0] fr,
                      input logic cm, input logic tk, input logic [31:0] ad,
                      input logic erp, input logic erd, input logic ejp,
                      input logic [3:0] eh, input logic [3:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rn;
    id_jump_detect = jd;
    full_req       = fr;
    wb_commit_jump = cm;
    wb_jump_taken  = tk;
    wb_jump_addr   = ad;
    e.sel  = sel;
    e.row  = row;
    e.name = scen;
    e.rp   = erp;
    e.rd   = erd;
    e.jp   = ejp;
    e.h    = eh;
    e.b    = eb;
    e.ra   = exp_ra;
    sb.push_back(e);
    row++;
  endtask

  task automatic idle(input logic erp, input logic erd, input logic ejp,
                      input logic [3:0] eh, input logic [3:0] eb);
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, erp, erd, ejp, eh, eb);
  endtask

  task automatic do_reset(input string name, input int s);
    scen   = name;
    sel    = s;
    row    = 0;
    exp_ra = '0;
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Taken jump, DRAIN_NOPS=1
    do_reset("taken_jump", 1);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1'b0, 1'b1, '0, B1);
    repeat (3) idle(1'b0, 1'b0, 1'b1, '0, B1);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, '0, B1);
    exp_ra = 32'h100;
    idle(1'b0, 1'b1, 1'b0, '0, B1);
    idle(1'b0, 1'b0, 1'b0, '0, '0);
`ifdef STALL_PERF_CNT_EN
    @(negedge clk);
    #2;
    n_checks++;
    if (pj_v[1] !== 32'd5 || pd_v[1] !== 32'd1 || pf_v[1] !== 32'd0)
      $display("FAIL perf_counters: got jump=%0d drain=%0d full=%0d; exp jump=5 drain=1 full=0",
               pj_v[1], pd_v[1], pf_v[1]);
    else
      n_pass++;
`endif

    // Not-taken jump, DRAIN_NOPS=3
    do_reset("not_taken_drain3", 3);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1'b0, 1'b1, '0, B1);
    repeat (3) idle(1'b0, 1'b0, 1'b1, '0, B1);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b1, '0, B1);
    repeat (3) idle(1'b0, 1'b0, 1'b0, '0, B1);
    idle(1'b0, 1'b0, 1'b0, '0, '0);

    // Full stall for 4 cycles, deferred jump detect, commit outside JWAIT
    do_reset("full_stall", 1);
    step(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) step(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, H, FB);
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, H, FB);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, H, FB);
    idle(1'b1, 1'b0, 1'b1, '0, B1);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, '0, B1);
    exp_ra = 32'h300;
    idle(1'b0, 1'b1, 1'b0, '0, B1);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) idle(1'b0, 1'b0, 1'b0, '0, '0);

    // Full stall coinciding with commit, DRAIN_NOPS=2: hold wins, both
    // drain bubbles follow once the stall is gone
    do_reset("full_in_drain", 2);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1'b0, 1'b1, '0, B1);
    step(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1, '0, B1);
    exp_ra = 32'h40;
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, H, FB);
    idle(1'b0, 1'b0, 1'b0, H, FB);
    repeat (2) idle(1'b0, 1'b0, 1'b0, '0, B1);
    idle(1'b0, 1'b0, 1'b0, '0, '0);

    // Asynchronous reset mid-JWAIT, later commit ignored
    do_reset("reset_in_jwait", 1);
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b1, 1'b0, 1'b1, '0, B1);
    idle(1'b0, 1'b0, 1'b1, '0, B1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) idle(1'b0, 1'b0, 1'b0, '0, '0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left, exp 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
